// File: rtl/pe_mac_pkg.sv
// Shared types and defaults for the PE MAC sequencer.
// State encoding, default widths and the length-counter width helper.
package pe_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    PSUM = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int INPUT_WIDTH_A_DEF = 8;
  localparam int INPUT_WIDTH_B_DEF = 8;
  localparam int MAX_LEN_DEF       = 12;

  // Counter width able to hold every value from 0 to max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pe_mac_sequencer.sv
// Operand-side control of one Eyeriss PE MultAdd: cfg_len MACs, optional psum add, valid/ready result.
// Define PE_PSUM_IN_EN to include the incoming-psum (PSUM) stage; otherwise MAC completes straight to OUT.
module pe_mac_sequencer
  import pe_mac_pkg::*;
#(
  parameter int INPUT_WIDTH_A = INPUT_WIDTH_A_DEF,
  parameter int INPUT_WIDTH_B = INPUT_WIDTH_B_DEF,
  parameter int OUTPUT_WIDTH  = INPUT_WIDTH_A + INPUT_WIDTH_B,
  parameter int MAX_LEN       = MAX_LEN_DEF,
  localparam int LW           = len_width(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LW-1:0]           cfg_len,
  output logic                    busy,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [INPUT_WIDTH_A-1:0] op_a,
  input  logic [INPUT_WIDTH_B-1:0] op_b,
  input  logic                    psum_in_valid,
  output logic                    psum_in_ready,
  input  logic [OUTPUT_WIDTH-1:0] psum_in,
  output logic                    psum_out_valid,
  input  logic                    psum_out_ready,
  output logic [OUTPUT_WIDTH-1:0] psum_out,
  output logic                    mac_en,
  output logic                    mac_clear,
  output logic                    mac_sel_b,
  output logic [INPUT_WIDTH_A-1:0] mac_a,
  output logic [INPUT_WIDTH_B-1:0] mac_b,
  output logic [OUTPUT_WIDTH-1:0] mac_add_a,
  output logic [OUTPUT_WIDTH-1:0] mac_add_b,
  input  logic [OUTPUT_WIDTH-1:0] mac_data_out
);

`ifdef PE_PSUM_IN_EN
  localparam state_t AFTER_MAC = PSUM;
`else
  localparam state_t AFTER_MAC = OUT;
  logic unused_psum_in;
  assign unused_psum_in = ^{psum_in_valid, psum_in};
`endif

  state_t        state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] cnt_reg, cnt_next;

  assign psum_out = mac_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Non-accumulating cycles select the adder path with a zero addend so data_out holds.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    busy           = (state_reg != IDLE);
    op_ready       = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    mac_en         = 1'b0;
    mac_clear      = 1'b0;
    mac_sel_b      = 1'b1;
    mac_a          = '0;
    mac_b          = '0;
    mac_add_a      = mac_data_out;
    mac_add_b      = '0;
    case (state_reg)
      IDLE: begin
        mac_clear = 1'b1;
        if (start) begin
          len_next   = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
          cnt_next   = '0;
          state_next = (cfg_len == '0) ? AFTER_MAC : MAC;
        end
      end
      MAC: begin
        op_ready = 1'b1;
        if (op_valid) begin
          mac_en    = 1'b1;
          mac_sel_b = 1'b0;
          mac_a     = op_a;
          mac_b     = op_b;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_next == len_reg) begin
            state_next = AFTER_MAC;
          end
        end
      end
`ifdef PE_PSUM_IN_EN
      PSUM: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) begin
          mac_add_b  = psum_in;
          state_next = OUT;
        end
      end
`endif
      OUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
